imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Registered immediate generator for the RISC-V core. It is the pipelined, parametrised successor of the single-cycle extender and sits between decode and execute in the pipelined core. It decodes all RV32I/RV64I immediate formats plus shift-amount and CSR-zimm forms, and sign- or zero-extends each to XLEN. Each result is buffered behind a valid/ready handshake with a two-entry skid buffer, so the block sustains full throughput under backpressure. It also keeps a saturating count of illegal-format requests.

## Interface
Parameters:
- XLEN, 32: output width; legal values are 32 and 64.
- CNTW, 8: width of the illegal-request counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  an input request is present.
- in_ready  out  1  the block can accept an input request.
- in_instr  in  32  raw instruction word.
- in_immsrc  in  3  format select.
- out_valid  out  1  an output result is present.
- out_ready  in  1  downstream accepts the output result.
- out_immext  out  XLEN  extended immediate.
- out_instr  out  32  instruction word carried alongside the immediate.
- out_illegal  out  1  the request used immsrc 3'b111.
- illegal_cnt  out  CNTW  saturating count of accepted illegal requests.

## Operation
Format decode, where S = instr[31] replicated to fill XLEN:
- 000 I: S, instr[31:20]
- 001 S: S, instr[31:25], instr[11:7]
- 010 B: S, instr[7], instr[30:25], instr[11:8], 0
- 011 J: S, instr[19:12], instr[20], instr[30:21], 0
- 100 U: S, instr[31:12], 12'b0 (sign-extended above bit 31 when XLEN=64)
- 101 shamt: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64
- 110 CSR zimm: zero-extended instr[19:15]
- 111 illegal: immext = 0 and illegal flag = 1

Handshake and buffering:
- Decode is combinational on the input side. The result is captured into a main register; a skid register sits behind it.
- Input handshake: acc_in = in_valid & in_ready.
- Output handshake: acc_out = out_valid & out_ready.
- in_ready is registered and equals !skid_valid.

Main/skid update, in priority order:
- Main empty, or main consumed this cycle: if skid holds data, skid moves to main, and a simultaneous acc_in lands in skid. Otherwise acc_in loads main directly.
- Main full and not consumed: acc_in loads skid.
- Ordering is strictly FIFO: no result is dropped, duplicated or reordered.

Flush:
- flush clears main_valid and skid_valid in the same cycle.
- An acc_in in the flush cycle is discarded.
- The counter is not cleared by flush.

Illegal counter:
- illegal_cnt increments by 1 on each acc_in with immsrc 3'b111.
- It saturates at 2^CNTW−1.
- It counts on acceptance, not on output.

Outputs are driven from the main register only.

## Timing
- Latency: a result appears on out_valid the cycle after acc_in, when main is empty or being consumed.
- Throughput: one result per cycle while out_ready = 1.
- Backpressure:
  - If out_ready drops, one further request is absorbed into skid.
  - in_ready deasserts the following cycle.
  - in_ready reasserts the cycle after the skid drains.
- Reset (rst_n = 0 at an edge): out_valid = 0, skid_valid = 0, in_ready = 1, out_immext = 0, out_instr = 0, out_illegal = 0, illegal_cnt = 0.
- Reset asserted mid-transfer discards all entries. No handshake completes in the reset cycle.
- While out_valid = 1 and out_ready = 0, out_immext, out_instr and out_illegal hold stable.
- Simultaneous acc_in and acc_out with skid empty and main full: main is replaced by the new result; out_valid stays at 1.

## Test plan
- **Formats, XLEN=32, out_ready=1.** Each input yields its result 1 cycle later:
  - 0xFFF00093/000 → 0xFFFFFFFF
  - 0xFE112E23/001 → 0xFFFFFFFC
  - 0xFFDFF06F/011 → 0xFFFFFFFC
  - 0x123450B7/100 → 0x12345000
  - 0x01F09093/101 → 0x0000001F
- **XLEN=64.**
  - 0x800000B7/100 → 0xFFFFFFFF80000000
  - 0x03F09093/101 → 0x000000000000003F
- **Backpressure.** Stream 4 back-to-back requests with out_ready=0 from cycle 2. Required: in_ready falls after 2 requests are accepted; no loss; on release, 4 results come out in order on consecutive cycles.
- **Flush.** Fill main and skid, then pulse flush together with in_valid. Next cycle: out_valid=0, in_ready=1, and the flushed-cycle request never appears.
- **Illegal requests, CNTW=2.** Send 5 requests with immsrc 3'b111. Each output has out_illegal=1 and immext=0; illegal_cnt reads 1, 2, 3, 3, 3.
- **Reset.** Assert rst_n=0 with both entries full and a pending request. Next edge: all outputs hold their reset values and in_ready=1.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Registered RISC-V immediate generator: decodes all immediate formats to XLEN and
// buffers results behind a valid/ready handshake with a main + skid register pair.
module imm_extend_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_immext,
    output logic [31:0]     out_instr,
    output logic            out_illegal,
    output logic [CNTW-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_I     = 3'b000,
        FMT_S     = 3'b001,
        FMT_B     = 3'b010,
        FMT_J     = 3'b011,
        FMT_U     = 3'b100,
        FMT_SHAMT = 3'b101,
        FMT_ZIMM  = 3'b110,
        FMT_ILL   = 3'b111
    } fmt_e;

    logic            acc_in;
    logic            acc_out;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    fmt_e            fmt;

    logic            main_valid;
    logic [XLEN-1:0] main_immext;
    logic [31:0]     main_instr;
    logic            main_illegal;

    logic            skid_valid;
    logic [XLEN-1:0] skid_immext;
    logic [31:0]     skid_instr;
    logic            skid_illegal;

    assign fmt     = fmt_e'(in_immsrc);
    assign acc_in  = in_valid & in_ready;
    assign acc_out = main_valid & out_ready;

    // Sign-fill first, then overwrite the low field; avoids zero-width replications at XLEN=32.
    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        unique case (fmt)
            FMT_I: begin
                dec_imm        = {XLEN{in_instr[31]}};
                dec_imm[11:0]  = in_instr[31:20];
            end
            FMT_S: begin
                dec_imm        = {XLEN{in_instr[31]}};
                dec_imm[11:0]  = {in_instr[31:25], in_instr[11:7]};
            end
            FMT_B: begin
                dec_imm        = {XLEN{in_instr[31]}};
                dec_imm[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            FMT_J: begin
                dec_imm        = {XLEN{in_instr[31]}};
                dec_imm[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            FMT_U: begin
                dec_imm        = {XLEN{in_instr[31]}};
                dec_imm[31:0]  = {in_instr[31:12], 12'b0};
            end
            FMT_SHAMT: begin
                if (XLEN == 64) dec_imm[5:0] = in_instr[25:20];
                else            dec_imm[4:0] = in_instr[24:20];
            end
            FMT_ZIMM: dec_imm[4:0] = in_instr[19:15];
            FMT_ILL:  dec_ill      = 1'b1;
            default:  dec_ill      = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid   <= 1'b0;
            main_immext  <= '0;
            main_instr   <= '0;
            main_illegal <= 1'b0;
            skid_valid   <= 1'b0;
            skid_immext  <= '0;
            skid_instr   <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || acc_out) begin
            if (skid_valid) begin
                main_valid   <= 1'b1;
                main_immext  <= skid_immext;
                main_instr   <= skid_instr;
                main_illegal <= skid_illegal;
                skid_valid   <= acc_in;
                if (acc_in) begin
                    skid_immext  <= dec_imm;
                    skid_instr   <= in_instr;
                    skid_illegal <= dec_ill;
                end
            end else begin
                main_valid <= acc_in;
                if (acc_in) begin
                    main_immext  <= dec_imm;
                    main_instr   <= in_instr;
                    main_illegal <= dec_ill;
                end
            end
        end else if (acc_in) begin
            skid_valid   <= 1'b1;
            skid_immext  <= dec_imm;
            skid_instr   <= in_instr;
            skid_illegal <= dec_ill;
        end
    end

    // Requests arriving during flush are discarded, so they are not counted either.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (acc_in && !flush && dec_ill && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNTW'(1);
        end
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_immext  = main_immext;
    assign out_instr   = main_instr;
    assign out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed steps with a scoreboard of expected results
// (XLEN=32/CNTW=2 instance) plus direct checks on an XLEN=64 instance.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_immsrc;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_immext, out_instr;
    logic [1:0]  illegal_cnt;

    logic        flush64, in_valid64, out_ready64;
    logic [31:0] in_instr64;
    logic [2:0]  in_immsrc64;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_immext64;
    logic [31:0] out_instr64;
    logic [7:0]  illegal_cnt64;

    imm_extend_pipe #(.XLEN(32), .CNTW(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_immsrc(in_immsrc),
        .out_valid(out_valid), .out_ready(out_ready), .out_immext(out_immext),
        .out_instr(out_instr), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_extend_pipe #(.XLEN(64), .CNTW(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_immsrc(in_immsrc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_immext(out_immext64),
        .out_instr(out_instr64), .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] instr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   ntests = 0;
    int   nfail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output side is compared before the input side is pushed, matching FIFO order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            check("sb_has_entry", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb_immext",  64'(out_immext), e.imm);
                check("sb_instr",   64'(out_instr),  64'(e.instr));
                check("sb_illegal", 64'(out_illegal), 64'(e.ill));
            end
        end
        if (!rst_n || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(pend);
    end

    task automatic drive(input logic [31:0] ins, input logic [2:0] src,
                         input logic [63:0] imm, input logic ill);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
        pend      = '{imm: imm, instr: ins, ill: ill};
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] imm, input logic ill);
        logic acc;
        int   budget;
        drive(ins, src, imm, ill);
        budget = 20;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) check("send_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] fvec_ins [7];
    logic [2:0]  fvec_src [7];
    logic [31:0] fvec_exp [7];

    initial begin
        fvec_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'hFFDFF06F,
                     32'h123450B7, 32'h03F09093, 32'h000AD073};
        fvec_src = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        fvec_exp = '{32'hFFFFFFFC + 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC,
                     32'h12345000, 32'h0000001F, 32'h00000015};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_immsrc = '0; pend = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
        in_instr64 = '0; in_immsrc64 = '0;
        cycle();
        cycle();
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_immext",      64'(out_immext),  64'd0);
        check("rst_instr",       64'(out_instr),   64'd0);
        check("rst_illegal",     64'(out_illegal), 64'd0);
        check("rst_cnt",         64'(illegal_cnt), 64'd0);
        check("rst64_out_valid", 64'(out_valid64), 64'd0);
        rst_n = 1'b1;
        cycle();

        // All formats back to back, one-cycle latency each
        for (int i = 0; i < 7; i++) begin
            send(fvec_ins[i], fvec_src[i], 64'(fvec_exp[i]), 1'b0);
            check("lat_valid", 64'(out_valid), 64'd1);
            check("lat_imm",   64'(out_immext), 64'(fvec_exp[i]));
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        check("idle_empty", 64'(out_valid), 64'd0);

        // XLEN=64 instance
        in_valid64 = 1'b1; in_instr64 = 32'h800000B7; in_immsrc64 = 3'b100;
        cycle();
        check("x64_u_valid", 64'(out_valid64), 64'd1);
        check("x64_u_imm",   out_immext64, 64'hFFFFFFFF80000000);
        in_instr64 = 32'h03F09093; in_immsrc64 = 3'b101;
        cycle();
        check("x64_shamt_imm", out_immext64, 64'h000000000000003F);
        in_valid64 = 1'b0;
        cycle();
        check("x64_drained", 64'(out_valid64), 64'd0);

        // Backpressure: A into main, B into skid, C stalls
        out_ready = 1'b1;
        send(32'h00100093, 3'b000, 64'd1, 1'b0);
        check("bp_ready_a", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        send(32'h00200093, 3'b000, 64'd2, 1'b0);
        check("bp_ready_fall", 64'(in_ready), 64'd0);
        drive(32'h00300093, 3'b000, 64'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_ready", 64'(in_ready),   64'd0);
            check("bp_hold_valid", 64'(out_valid),  64'd1);
            check("bp_hold_imm",   64'(out_immext), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk); check("bp_out0", 64'(out_valid), 64'd1);
        cycle();
        @(negedge clk); check("bp_out1", 64'(out_valid), 64'd1);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        cycle();
        drive(32'h00400093, 3'b000, 64'd4, 1'b0);
        @(negedge clk); check("bp_out2", 64'(out_valid), 64'd1);
        cycle();
        in_valid = 1'b0;
        @(negedge clk); check("bp_out3", 64'(out_valid), 64'd1);
        cycle();
        check("bp_done", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(q.size()), 64'd0);

        // Flush with main and skid full plus a request in the same cycle
        out_ready = 1'b0;
        send(32'h00500093, 3'b000, 64'd5, 1'b0);
        send(32'h00600093, 3'b000, 64'd6, 1'b0);
        check("fl_full", 64'(in_ready), 64'd0);
        cycle();
        drive(32'h00700093, 3'b000, 64'd7, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fl_no_ghost", 64'(out_valid), 64'd0);
        end

        // Illegal requests saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send(32'hFFFFFFFF - 32'(i), 3'b111, 64'd0, 1'b1);
            check("ill_cnt", 64'(illegal_cnt), 64'((i < 3) ? i + 1 : 3));
            check("ill_flag", 64'(out_illegal), 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // Reset with both entries full and a pending request
        out_ready = 1'b0;
        send(32'h00800093, 3'b000, 64'd8, 1'b0);
        send(32'h00900093, 3'b000, 64'd9, 1'b0);
        drive(32'hFFFFFFFF, 3'b111, 64'd0, 1'b1);
        rst_n = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("rst2_out_valid", 64'(out_valid),   64'd0);
        check("rst2_in_ready",  64'(in_ready),    64'd1);
        check("rst2_immext",    64'(out_immext),  64'd0);
        check("rst2_instr",     64'(out_instr),   64'd0);
        check("rst2_illegal",   64'(out_illegal), 64'd0);
        check("rst2_cnt",       64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        check("rst2_stays_empty", 64'(out_valid), 64'd0);
        check("final_sb_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
